multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RISC-V CPU datapath. It replaces the combinational decoder and free-running PC increment. It steps each instruction through fetch, decode, execute, memory and writeback, handshaking with instruction and data memory. It drives the register write enable, immediate mux select, ALU operation, PC increment and instruction-register load.

---
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control sequencer for the RISC-V datapath.
// Latency (ack on first request cycle): R/I and store 4 cycles, load 5 cycles, FETCH entry to FETCH entry.
// Backpressure: FETCH/MEM hold their request until ack; a wait of MAXWAIT cycles with no ack traps.
// Optional counters: define MULTICYCLE_CTRL_PERF_CNT_EN to add the retired and stall_cycles ports.
module multicycle_ctrl #(
    parameter int unsigned MAXWAIT = 15,
    parameter int unsigned WW      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       irw,
    output logic       incr,
    output logic       regw,
    output logic       imm,
    output logic       memtoreg,
    output logic [3:0] AluOp,
    output logic [2:0] state,
    output logic       illegal
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    // Instruction class latched at DECODE exit; steers EXEC/MEM/WB routing.
    localparam logic [1:0] C_R  = 2'd0;
    localparam logic [1:0] C_I  = 2'd1;
    localparam logic [1:0] C_LD = 2'd2;
    localparam logic [1:0] C_ST = 2'd3;

    localparam logic [WW-1:0] WAIT_MAX = WW'(MAXWAIT);

    logic [2:0]    state_q, state_d;
    logic [WW-1:0] wait_q,  wait_d;
    logic [1:0]    cls_q,   cls_d;
    logic          imm_q,   imm_d;
    logic [3:0]    alu_q,   alu_d;

    // Only funct7[5] distinguishes SUB/SRA; the remaining bits are don't-care here.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // State, wait counter and decoded operand controls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cls_q   <= C_R;
            imm_q   <= 1'b0;
            alu_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cls_q   <= cls_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
        end
    end

    // Next-state logic: handshakes with timeout, opcode classification, class routing.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cls_d   = cls_q;
        imm_d   = imm_q;
        alu_d   = alu_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                    wait_d  = '0;
                end else if (wait_q == WAIT_MAX) begin
                    state_d = S_TRAP;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                case (opcode)
                    OP_R: begin
                        cls_d = C_R;
                        imm_d = 1'b0;
                        alu_d = {funct7[5], funct3};
                    end
                    OP_I: begin
                        cls_d = C_I;
                        imm_d = 1'b1;
                        // Only shift-right distinguishes SRLI/SRAI via funct7[5].
                        alu_d = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
                    end
                    OP_LD: begin
                        cls_d = C_LD;
                        imm_d = 1'b1;
                        alu_d = 4'b0000;
                    end
                    OP_ST: begin
                        cls_d = C_ST;
                        imm_d = 1'b1;
                        alu_d = 4'b0000;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                state_d = (cls_q == C_LD || cls_q == C_ST) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = (cls_q == C_LD) ? S_WB : S_FETCH;
                    wait_d  = '0;
                end else if (wait_q == WAIT_MAX) begin
                    state_d = S_TRAP;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Outputs: Moore on state, except irw and the store incr which follow ack.
    // Reset forces every flag low immediately, dropping any outstanding request.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        irw      = 1'b0;
        incr     = 1'b0;
        regw     = 1'b0;
        memtoreg = 1'b0;
        illegal  = 1'b0;
        imm      = imm_q;
        AluOp    = alu_q;
        state    = state_q;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    irw      = imem_ack;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls_q == C_ST);
                    incr     = dmem_ack && (cls_q == C_ST);
                end
                S_WB: begin
                    regw     = 1'b1;
                    incr     = 1'b1;
                    memtoreg = (cls_q == C_LD);
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;
    logic        stall_now;

    assign stall_now    = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
    assign retired      = retired_q;
    assign stall_cycles = stall_q;

    // Retired count wraps; stall count saturates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (incr) begin
                retired_q <= retired_q + 32'd1;
            end
            if (stall_now && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: R/I/load/store flows, illegal trap, fetch timeout, async reset.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Expected values are hand-derived from the control sequence definition.
module tb_multicycle_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       imem_req, imem_ack;
    logic       dmem_req, dmem_we, dmem_ack;
    logic       irw, incr, regw, imm, memtoreg, illegal;
    logic [3:0] AluOp;
    logic [2:0] state;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [31:0] retired, stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int c0     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    multicycle_ctrl #(.MAXWAIT(15), .WW(8)) dut (
        .clock(clock), .reset(reset),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .irw(irw), .incr(incr), .regw(regw), .imm(imm), .memtoreg(memtoreg),
        .AluOp(AluOp), .state(state), .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
        , .retired(retired), .stall_cycles(stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present an instruction in FETCH with ack in the first cycle, then advance to DECODE.
    task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        imem_ack = 1'b1;
        #1;
        chk("fetch_state", 32'(state), 32'd0);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_irw", 32'(irw), 32'd1);
        c0 = cyc;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("decode_state", 32'(state), 32'd1);
        chk("decode_irw", 32'(irw), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        opcode   = 7'd0;
        funct3   = 3'd0;
        funct7   = 7'd0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_aluop", 32'(AluOp), 32'd0);
        chk("rst_imm", 32'(imm), 32'd0);
        chk("rst_regw_incr", 32'({regw, incr}), 32'd0);
        reset = 1'b0;
        #1;

        // R-type ADD: 0,1,2,4,0
        fetch(7'b0110011, 3'b000, 7'b0000000);
        tick();
        // Stray acks while no request is high must be ignored
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #1;
        chk("add_exec_state", 32'(state), 32'd2);
        chk("add_aluop", 32'(AluOp), 32'h0);
        chk("add_imm", 32'(imm), 32'd0);
        chk("add_exec_incr_irw", 32'({incr, irw, regw}), 32'd0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        tick();
        chk("add_wb_state", 32'(state), 32'd4);
        chk("add_wb_regw_incr", 32'({regw, incr, memtoreg}), 32'b110);
        tick();
        chk("add_back_fetch", 32'(state), 32'd0);
        chk("add_latency", 32'(cyc - c0), 32'd4);
        chk("add_fetch_incr", 32'(incr), 32'd0);

        // I-type SRAI
        fetch(7'b0010011, 3'b101, 7'b0100000);
        tick();
        chk("srai_exec_state", 32'(state), 32'd2);
        chk("srai_aluop_exec", 32'(AluOp), 32'hd);
        chk("srai_imm_exec", 32'(imm), 32'd1);
        chk("srai_exec_incr", 32'(incr), 32'd0);
        tick();
        chk("srai_wb_state", 32'(state), 32'd4);
        chk("srai_aluop_wb", 32'(AluOp), 32'hd);
        chk("srai_imm_wb", 32'(imm), 32'd1);
        chk("srai_wb_incr", 32'(incr), 32'd1);
        tick();
        chk("srai_back_fetch", 32'(state), 32'd0);
        chk("srai_latency", 32'(cyc - c0), 32'd4);

        // Load with dmem_ack on the fourth MEM cycle
        fetch(7'b0000011, 3'b010, 7'b0000000);
        tick();
        chk("ld_exec_state", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_mem_state", 32'(state), 32'd3);
            chk("ld_mem_req", 32'(dmem_req), 32'd1);
            chk("ld_mem_we", 32'(dmem_we), 32'd0);
            chk("ld_mem_incr", 32'(incr), 32'd0);
        end
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("ld_mem_req_ack", 32'(dmem_req), 32'd1);
        chk("ld_mem_aluop_imm", 32'({AluOp, imm}), 32'b00001);
        chk("ld_mem_ack_incr", 32'(incr), 32'd0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("ld_wb_state", 32'(state), 32'd4);
        chk("ld_wb_flags", 32'({regw, incr, memtoreg, dmem_req}), 32'b1110);
        tick();
        chk("ld_back_fetch", 32'(state), 32'd0);
        chk("ld_latency", 32'(cyc - c0), 32'd8);

        // Store, ack on first MEM cycle: incr in MEM, no WB
        fetch(7'b0100011, 3'b010, 7'b0000000);
        tick();
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("st_mem_state", 32'(state), 32'd3);
        chk("st_mem_req_we", 32'({dmem_req, dmem_we}), 32'b11);
        chk("st_mem_incr", 32'(incr), 32'd1);
        chk("st_mem_regw", 32'(regw), 32'd0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("st_back_fetch", 32'(state), 32'd0);
        chk("st_latency", 32'(cyc - c0), 32'd4);
        chk("st_fetch_regw_incr", 32'({regw, incr}), 32'd0);

        // Illegal opcode traps from DECODE and stays silent
        fetch(7'b1111111, 3'b000, 7'b0000000);
        tick();
        chk("ill_state", 32'(state), 32'd7);
        chk("ill_flag", 32'(illegal), 32'd1);
        for (int i = 0; i < 20; i++) begin
            imem_ack = i[0];
            dmem_ack = ~i[0];
            tick();
            chk("ill_no_req", 32'({imem_req, dmem_req, irw, incr, regw}), 32'd0);
            chk("ill_hold", 32'({state, illegal}), 32'b1111);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        reset = 1'b1;
        #1;
        chk("ill_rst_state", 32'(state), 32'd0);
        chk("ill_rst_flag", 32'(illegal), 32'd0);
        tick();
        reset = 1'b0;
        #1;

        // Fetch timeout: 15 idle cycles still fetching, the 16th traps
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("to_still_fetch", 32'(state), 32'd0);
        chk("to_still_req", 32'(imem_req), 32'd1);
        tick();
        chk("to_trap_state", 32'(state), 32'd7);
        chk("to_trap_flag", 32'({illegal, imem_req}), 32'b10);

        // Reset asserted mid-MEM drops the request before the next edge
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        #1;
        fetch(7'b0000011, 3'b000, 7'b0000000);
        tick();
        tick();
        chk("mr_mem_req", 32'({state, dmem_req}), 32'b0111);
        reset = 1'b1;
        #1;
        chk("mr_req_drop", 32'(dmem_req), 32'd0);
        chk("mr_state", 32'(state), 32'd0);
        chk("mr_imem_req", 32'(imem_req), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("mr_release_req", 32'(imem_req), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
